// File: rtl/ethernet_pkg.sv
// Shared Ethernet constants and FSM encoding for the MII receive path.
package ethernet_pkg;

    // Receive FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPreamble = 3'd1,
        StHeader   = 3'd2,
        StData     = 3'd3,
        StDrop     = 3'd4
    } eth_rx_state_e;

    localparam logic [3:0]  PRE_NIB             = 4'h5;
    localparam logic [3:0]  SFD_NIB             = 4'hD;
    localparam int unsigned MAC_HDR_LEN         = 12;
    localparam int unsigned MAC_ADDR_LEN        = 6;
    localparam int unsigned DEFAULT_PAYLOAD_LEN = 1360;

    // Byte idx of a MAC address in wire order (idx 0 is bits [47:40])
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

endpackage

// File: rtl/eth_rx_nibble_pack.sv
// Packs MII nibbles (low half first) into bytes with a strobe on the high half.
module eth_rx_nibble_pack (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_restart,
    input  logic       i_nib_vld,
    input  logic [3:0] i_nib,
    output logic [7:0] o_byte,
    output logic       o_byte_stb
);

    logic       r_phase;
    logic [3:0] r_low;

    // Phase toggles per accepted nibble; the low half is held until its partner arrives
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= 1'b0;
            r_low   <= 4'h0;
        end else if (i_restart) begin
            r_phase <= 1'b0;
            r_low   <= 4'h0;
        end else if (i_nib_vld) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_low <= i_nib;
            end
        end
    end

    // Byte is complete while the high nibble is presented
    always_comb begin
        o_byte     = {i_nib, r_low};
        o_byte_stb = i_nib_vld & r_phase;
    end

endmodule

// File: rtl/ethernet_rx.sv
// MII receive framer: preamble/SFD search, MAC header filter, fixed-length payload delivery.
module ethernet_rx
    import ethernet_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = DEFAULT_PAYLOAD_LEN,
    parameter int unsigned MIN_PRE_NIB = 10,
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_FE_C0,
    parameter bit          CHECK_MAC   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_ctrl,
    input  logic [3:0] i_phy_rxd,
    output logic [7:0] o_dataout,
    output logic       o_data_valid,
    output logic       o_frame_start,
    output logic       o_frame_done,
    output logic       o_frame_err
);

    localparam logic [3:0]  MinPre  = 4'(MIN_PRE_NIB);
    localparam logic [10:0] HdrLast = 11'(MAC_HDR_LEN - 1);
    localparam logic [10:0] MacLen  = 11'(MAC_ADDR_LEN);
    localparam logic [10:0] PayLast = 11'(PAYLOAD_LEN - 1);

    // Input sample stage
    logic          r_rx_dv;
    logic [3:0]    r_rxd;

    // FSM and counters
    eth_rx_state_e r_state, w_state_nxt;
    logic [3:0]    r_pre_cnt, w_pre_cnt_nxt;
    logic [10:0]   r_byte_cnt, w_byte_cnt_nxt;
    logic          r_mac_miss, w_mac_miss_nxt;
    logic          r_bcast_miss, w_bcast_miss_nxt;

    // Output registers; done is delayed so it lands two cycles after the last strobe
    logic [7:0]    r_dataout, w_dataout_nxt;
    logic          r_data_valid, w_data_valid_nxt;
    logic          r_frame_start, w_frame_start_nxt;
    logic          r_frame_err, w_frame_err_nxt;
    logic          r_done_dly, r_done_dly2, r_frame_done, w_done_req;

    // Nibble packer interface
    logic          w_restart;
    logic          w_nib_vld;
    logic [7:0]    w_byte;
    logic          w_byte_stb;

    eth_rx_nibble_pack u_pack (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_restart  (w_restart),
        .i_nib_vld  (w_nib_vld),
        .i_nib      (r_rxd),
        .o_byte     (w_byte),
        .o_byte_stb (w_byte_stb)
    );

    // Register the raw PHY pins once; all decode uses the sampled copies
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_dv <= 1'b0;
            r_rxd   <= 4'h0;
        end else begin
            r_rx_dv <= i_rx_ctrl;
            r_rxd   <= i_phy_rxd;
        end
    end

    // State, counters and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_pre_cnt     <= 4'd0;
            r_byte_cnt    <= 11'd0;
            r_mac_miss    <= 1'b0;
            r_bcast_miss  <= 1'b0;
            r_dataout     <= 8'h00;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_err   <= 1'b0;
            r_done_dly    <= 1'b0;
            r_done_dly2   <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pre_cnt     <= w_pre_cnt_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_mac_miss    <= w_mac_miss_nxt;
            r_bcast_miss  <= w_bcast_miss_nxt;
            r_dataout     <= w_dataout_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_done_dly    <= w_done_req;
            r_done_dly2   <= r_done_dly;
            r_frame_done  <= r_done_dly2;
        end
    end

    // Next-state, counter and output decode on the sampled nibble
    always_comb begin
        w_state_nxt       = r_state;
        w_pre_cnt_nxt     = r_pre_cnt;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_mac_miss_nxt    = r_mac_miss;
        w_bcast_miss_nxt  = r_bcast_miss;
        w_dataout_nxt     = r_dataout;
        w_data_valid_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;
        w_done_req        = 1'b0;
        w_restart         = 1'b0;
        w_nib_vld         = 1'b0;

        case (r_state)
            StIdle: begin
                if (r_rx_dv && r_rxd == PRE_NIB) begin
                    w_state_nxt   = StPreamble;
                    w_pre_cnt_nxt = 4'd1;
                end
            end

            StPreamble: begin
                if (!r_rx_dv) begin
                    w_state_nxt = StIdle;
                end else if (r_rxd == PRE_NIB) begin
                    if (r_pre_cnt != 4'hF) begin
                        w_pre_cnt_nxt = r_pre_cnt + 4'd1;
                    end
                end else if (r_rxd == SFD_NIB && r_pre_cnt >= MinPre) begin
                    w_state_nxt      = StHeader;
                    w_byte_cnt_nxt   = 11'd0;
                    w_mac_miss_nxt   = 1'b0;
                    w_bcast_miss_nxt = 1'b0;
                    w_restart        = 1'b1;
                end else begin
                    // Short preamble or junk: no frame was accepted, so no error pulse
                    w_state_nxt = StDrop;
                end
            end

            StHeader: begin
                if (!r_rx_dv) begin
                    w_state_nxt     = StIdle;
                    w_frame_err_nxt = 1'b1;
                end else begin
                    w_nib_vld = 1'b1;
                    if (w_byte_stb) begin
                        if (r_byte_cnt < MacLen) begin
                            if (w_byte != mac_byte(LOCAL_MAC, r_byte_cnt[2:0])) begin
                                w_mac_miss_nxt = 1'b1;
                            end
                            if (w_byte != 8'hFF) begin
                                w_bcast_miss_nxt = 1'b1;
                            end
                        end
                        if (r_byte_cnt == HdrLast) begin
                            if (CHECK_MAC && r_mac_miss && r_bcast_miss) begin
                                w_state_nxt = StDrop;
                            end else begin
                                w_state_nxt    = StData;
                                w_byte_cnt_nxt = 11'd0;
                            end
                        end else begin
                            w_byte_cnt_nxt = r_byte_cnt + 11'd1;
                        end
                    end
                end
            end

            StData: begin
                if (!r_rx_dv) begin
                    w_state_nxt     = StIdle;
                    w_frame_err_nxt = 1'b1;
                end else begin
                    w_nib_vld = 1'b1;
                    if (w_byte_stb) begin
                        w_dataout_nxt     = w_byte;
                        w_data_valid_nxt  = 1'b1;
                        w_frame_start_nxt = (r_byte_cnt == 11'd0);
                        if (r_byte_cnt == PayLast) begin
                            // Remaining bytes (FCS, padding) are swallowed in DROP
                            w_state_nxt = StDrop;
                            w_done_req  = 1'b1;
                        end else begin
                            w_byte_cnt_nxt = r_byte_cnt + 11'd1;
                        end
                    end
                end
            end

            StDrop: begin
                if (!r_rx_dv) begin
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Drive ports from registers
    always_comb begin
        o_dataout     = r_dataout;
        o_data_valid  = r_data_valid;
        o_frame_start = r_frame_start;
        o_frame_done  = r_frame_done;
        o_frame_err   = r_frame_err;
    end

endmodule
